// File: rtl/data_mem_access_ctrl_if.sv
// Data memory bus between the MEM-stage access controller (master) and a
// multi-cycle memory with a ready handshake (slave).
interface data_mem_access_ctrl_if;
    logic        dm_read;
    logic        dm_write;
    logic [29:0] dm_address;
    logic [31:0] dm_writedata;
    logic [3:0]  dm_byteenable;
    logic [31:0] dm_readdata;
    logic        dm_ready;

    modport master (
        output dm_read, dm_write, dm_address, dm_writedata, dm_byteenable,
        input  dm_readdata, dm_ready
    );

    modport slave (
        input  dm_read, dm_write, dm_address, dm_writedata, dm_byteenable,
        output dm_readdata, dm_ready
    );
endinterface

// File: rtl/data_mem_access_ctrl.sv
// Sequences MEM-stage loads/stores onto a multi-cycle data memory, stalling the
// pipeline while in flight and aligning/extending load results by func3.
module data_mem_access_ctrl #(
    parameter int TIMEOUT_CYCLES = 64,
    parameter int CNT_W          = 7
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [2:0]  func3,
    input  logic [31:0] address,
    input  logic [31:0] write_data,
    output logic        busywait,
    output logic [31:0] read_data_out,
    output logic        access_fault,
    data_mem_access_ctrl_if.master dm
);

    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [2:0]       func3_q;
    logic [1:0]       offset_q;
    logic             timeout_q;

    logic        request;
    logic        func_ok;
    logic        align_ok;
    logic        legal;
    logic [3:0]  store_be;
    logic [31:0] store_wd;
    logic [31:0] shifted;
    logic [31:0] load_value;

    // A store wins when both request lines are high, so legality follows the store table.
    always_comb begin
        request  = mem_read | mem_write;
        func_ok  = mem_write ? (func3 inside {3'b000, 3'b001, 3'b010})
                             : (func3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
        case (func3[1:0])
            2'b01:   align_ok = ~address[0];
            2'b10:   align_ok = (address[1:0] == 2'b00);
            default: align_ok = 1'b1;
        endcase
        legal        = func_ok & align_ok;
        busywait     = (state == ACCESS) | ((state == IDLE) & request & legal);
        access_fault = ((state == IDLE) & request & ~legal) | ((state == DONE) & timeout_q);
    end

    always_comb begin
        store_be = 4'b0000;
        store_wd = write_data;
        case (func3[1:0])
            2'b00: begin
                store_be = 4'b0001 << address[1:0];
                store_wd = {4{write_data[7:0]}};
            end
            2'b01: begin
                store_be = 4'b0011 << {address[1], 1'b0};
                store_wd = {2{write_data[15:0]}};
            end
            default: begin
                store_be = 4'b1111;
                store_wd = write_data;
            end
        endcase
    end

    always_comb begin
        shifted = dm.dm_readdata >> {offset_q, 3'b000};
        case (func3_q)
            3'b000:  load_value = {{24{shifted[7]}}, shifted[7:0]};
            3'b100:  load_value = {24'h0, shifted[7:0]};
            3'b001:  load_value = {{16{shifted[15]}}, shifted[15:0]};
            3'b101:  load_value = {16'h0, shifted[15:0]};
            default: load_value = shifted;
        endcase
    end

    // Strobes drop on completion or timeout; address/data/enables keep their last value.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state            <= IDLE;
            cnt              <= '0;
            func3_q          <= 3'b000;
            offset_q         <= 2'b00;
            timeout_q        <= 1'b0;
            read_data_out    <= 32'h0;
            dm.dm_read       <= 1'b0;
            dm.dm_write      <= 1'b0;
            dm.dm_address    <= 30'h0;
            dm.dm_writedata  <= 32'h0;
            dm.dm_byteenable <= 4'b0000;
        end else begin
            case (state)
                IDLE: begin
                    timeout_q <= 1'b0;
                    if (request && legal) begin
                        dm.dm_read       <= ~mem_write;
                        dm.dm_write      <= mem_write;
                        dm.dm_address    <= address[31:2];
                        dm.dm_writedata  <= mem_write ? store_wd : 32'h0;
                        dm.dm_byteenable <= mem_write ? store_be : 4'b0000;
                        func3_q          <= func3;
                        offset_q         <= address[1:0];
                        cnt              <= '0;
                        state            <= ACCESS;
                    end
                end
                ACCESS: begin
                    cnt <= cnt + 1'b1;
                    if (dm.dm_ready) begin
                        if (dm.dm_read) read_data_out <= load_value;
                        dm.dm_read  <= 1'b0;
                        dm.dm_write <= 1'b0;
                        state       <= DONE;
                    end else if (cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                        dm.dm_read    <= 1'b0;
                        dm.dm_write   <= 1'b0;
                        read_data_out <= 32'h0;
                        timeout_q     <= 1'b1;
                        state         <= DONE;
                    end
                end
                DONE: begin
                    timeout_q <= 1'b0;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_data_mem_access_ctrl.sv
// Directed scoreboard bench for data_mem_access_ctrl: loads, stores, illegal
// requests, memory timeout, reset mid-access and back-to-back loads.
module tb_data_mem_access_ctrl;

    logic        CLK = 1'b0;
    logic        RESET;
    logic        mem_read;
    logic        mem_write;
    logic [2:0]  func3;
    logic [31:0] address;
    logic [31:0] write_data;
    logic        busywait;
    logic [31:0] read_data_out;
    logic        access_fault;

    data_mem_access_ctrl_if dm_bus ();

    data_mem_access_ctrl #(.TIMEOUT_CYCLES(64), .CNT_W(7)) dut (
        .CLK           (CLK),
        .RESET         (RESET),
        .mem_read      (mem_read),
        .mem_write     (mem_write),
        .func3         (func3),
        .address       (address),
        .write_data    (write_data),
        .busywait      (busywait),
        .read_data_out (read_data_out),
        .access_fault  (access_fault),
        .dm            (dm_bus)
    );

    always #5 CLK = ~CLK;

    int          checks = 0;
    int          errors = 0;
    int          cycle_count = 0;
    int          busy_cycles;
    int          strobe_cycles;
    int          start_cycle;
    logic [31:0] exp_q[$];
    logic [31:0] last_rd;
    logic [29:0] seen_addr;
    logic [3:0]  seen_be;
    logic [31:0] seen_wd;
    logic        seen_rd;
    logic        seen_wr;

    always @(posedge CLK) cycle_count++;

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Drives one request from IDLE and plays the memory until busywait falls (DONE).
    // delay = ACCESS cycle on which dm_ready is raised, 0 = never.
    task automatic apply_stimulus(input logic rd, input logic wr, input logic [2:0] f3,
                                  input logic [31:0] addr, input logic [31:0] wdata,
                                  input logic [31:0] rdata, input int delay);
        mem_read      = rd;
        mem_write     = wr;
        func3         = f3;
        address       = addr;
        write_data    = wdata;
        busy_cycles   = 0;
        strobe_cycles = 0;
        #1;
        while (busywait && busy_cycles < 200) begin
            busy_cycles++;
            if (dm_bus.dm_read || dm_bus.dm_write) begin
                strobe_cycles++;
                if (strobe_cycles == 1) begin
                    seen_addr = dm_bus.dm_address;
                    seen_be   = dm_bus.dm_byteenable;
                    seen_wd   = dm_bus.dm_writedata;
                    seen_rd   = dm_bus.dm_read;
                    seen_wr   = dm_bus.dm_write;
                end
                if (delay != 0 && strobe_cycles == delay) begin
                    dm_bus.dm_readdata = rdata;
                    dm_bus.dm_ready    = 1'b1;
                end
            end
            @(posedge CLK); #1;
            dm_bus.dm_ready    = 1'b0;
            dm_bus.dm_readdata = 32'hDEAD_BEEF;
        end
        check_output("busy_bounded", 32'(busy_cycles < 200), 32'd1);
    endtask

    task automatic check_done(input string tag, input logic fault_exp);
        logic [31:0] exp;
        if (exp_q.size() == 0) begin
            check_output({tag, "_scoreboard_empty"}, 32'(exp_q.size()), 32'd1);
        end else begin
            exp = exp_q.pop_front();
            check_output({tag, "_read_data_out"}, read_data_out, exp);
            last_rd = exp;
        end
        check_output({tag, "_fault"}, 32'(access_fault), 32'(fault_exp));
        check_output({tag, "_done_busy"}, 32'(busywait), 32'd0);
        check_output({tag, "_strobes_dropped"}, 32'({dm_bus.dm_read, dm_bus.dm_write}), 32'd0);
    endtask

    task automatic go_idle();
        mem_read  = 1'b0;
        mem_write = 1'b0;
        @(posedge CLK); #1;
    endtask

    task automatic apply_illegal(input string tag, input logic rd, input logic wr,
                                 input logic [2:0] f3, input logic [31:0] addr);
        mem_read  = rd;
        mem_write = wr;
        func3     = f3;
        address   = addr;
        #1;
        check_output({tag, "_fault"}, 32'(access_fault), 32'd1);
        check_output({tag, "_busy"}, 32'(busywait), 32'd0);
        @(posedge CLK); #1;
        check_output({tag, "_no_strobe"}, 32'({dm_bus.dm_read, dm_bus.dm_write}), 32'd0);
        check_output({tag, "_rdo_kept"}, read_data_out, last_rd);
        mem_read  = 1'b0;
        mem_write = 1'b0;
        #1;
        check_output({tag, "_fault_pulse"}, 32'(access_fault), 32'd0);
        @(posedge CLK); #1;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        RESET              = 1'b1;
        mem_read           = 1'b0;
        mem_write          = 1'b0;
        func3              = 3'b000;
        address            = 32'h0;
        write_data         = 32'h0;
        dm_bus.dm_ready    = 1'b0;
        dm_bus.dm_readdata = 32'hDEAD_BEEF;
        last_rd            = 32'h0;
        repeat (2) @(posedge CLK);
        #1;
        check_output("rst_busy", 32'(busywait), 32'd0);
        check_output("rst_rdo", read_data_out, 32'h0);
        check_output("rst_fault", 32'(access_fault), 32'd0);
        check_output("rst_strobes", 32'({dm_bus.dm_read, dm_bus.dm_write}), 32'd0);
        check_output("rst_addr", 32'(dm_bus.dm_address), 32'h0);
        check_output("rst_be", 32'(dm_bus.dm_byteenable), 32'h0);
        check_output("rst_wd", dm_bus.dm_writedata, 32'h0);
        RESET = 1'b0;
        @(posedge CLK); #1;

        $display("[TB] lb from 0x103, ready on third ACCESS cycle");
        exp_q.push_back(32'hFFFF_FF80);
        apply_stimulus(1'b1, 1'b0, 3'b000, 32'h0000_0103, 32'h0, 32'h80FF_1234, 3);
        check_output("lb_busy_cycles", 32'(busy_cycles), 32'd4);
        check_output("lb_addr", 32'(seen_addr), 32'h40);
        check_output("lb_rd", 32'(seen_rd), 32'd1);
        check_output("lb_be", 32'(seen_be), 32'h0);
        check_done("lb", 1'b0);
        go_idle();

        $display("[TB] sh to 0x202");
        exp_q.push_back(last_rd);
        apply_stimulus(1'b0, 1'b1, 3'b001, 32'h0000_0202, 32'h1234_ABCD, 32'h0, 2);
        check_output("sh_busy_cycles", 32'(busy_cycles), 32'd3);
        check_output("sh_wr", 32'(seen_wr), 32'd1);
        check_output("sh_be", 32'(seen_be), 32'b1100);
        check_output("sh_wd", seen_wd, 32'hABCD_ABCD);
        check_output("sh_addr", 32'(seen_addr), 32'h80);
        check_done("sh", 1'b0);
        go_idle();

        $display("[TB] sb to 0x101");
        exp_q.push_back(last_rd);
        apply_stimulus(1'b0, 1'b1, 3'b000, 32'h0000_0101, 32'h5566_77AB, 32'h0, 1);
        check_output("sb_be", 32'(seen_be), 32'b0010);
        check_output("sb_wd", seen_wd, 32'hABAB_ABAB);
        check_output("sb_addr", 32'(seen_addr), 32'h40);
        check_done("sb", 1'b0);
        go_idle();

        $display("[TB] illegal requests");
        apply_illegal("lw_misaligned", 1'b1, 1'b0, 3'b010, 32'h0000_0006);
        apply_illegal("lhu_misaligned", 1'b1, 1'b0, 3'b101, 32'h0000_0001);
        apply_illegal("load_f3_011", 1'b1, 1'b0, 3'b011, 32'h0000_0000);
        apply_illegal("store_f3_100", 1'b0, 1'b1, 3'b100, 32'h0000_0000);
        apply_illegal("sw_misaligned", 1'b0, 1'b1, 3'b010, 32'h0000_0002);

        $display("[TB] lhu / lh / lbu extension");
        exp_q.push_back(32'h0000_8001);
        apply_stimulus(1'b1, 1'b0, 3'b101, 32'h0000_0002, 32'h0, 32'h8001_0000, 1);
        check_done("lhu", 1'b0);
        go_idle();
        exp_q.push_back(32'hFFFF_8001);
        apply_stimulus(1'b1, 1'b0, 3'b001, 32'h0000_0002, 32'h0, 32'h8001_0000, 2);
        check_done("lh", 1'b0);
        go_idle();
        exp_q.push_back(32'h0000_00F1);
        apply_stimulus(1'b1, 1'b0, 3'b100, 32'h0000_0101, 32'h0, 32'h0000_F100, 1);
        check_done("lbu", 1'b0);
        go_idle();

        $display("[TB] read and write together become a store");
        exp_q.push_back(last_rd);
        apply_stimulus(1'b1, 1'b1, 3'b010, 32'h0000_0010, 32'hCAFE_F00D, 32'h0, 1);
        check_output("both_rd", 32'(seen_rd), 32'd0);
        check_output("both_wr", 32'(seen_wr), 32'd1);
        check_output("both_be", 32'(seen_be), 32'b1111);
        check_output("both_wd", seen_wd, 32'hCAFE_F00D);
        check_output("both_addr", 32'(seen_addr), 32'h4);
        check_done("both", 1'b0);
        go_idle();

        $display("[TB] dm_ready while idle is ignored");
        dm_bus.dm_ready    = 1'b1;
        dm_bus.dm_readdata = 32'h1234_5678;
        @(posedge CLK); #1;
        dm_bus.dm_ready    = 1'b0;
        dm_bus.dm_readdata = 32'hDEAD_BEEF;
        check_output("idle_ready_rdo", read_data_out, last_rd);
        check_output("idle_ready_busy", 32'(busywait), 32'd0);

        $display("[TB] reset in the middle of an access");
        mem_read  = 1'b1;
        func3     = 3'b010;
        address   = 32'h0000_0044;
        @(posedge CLK); #1;
        check_output("rstmid_strobe_on", 32'(dm_bus.dm_read), 32'd1);
        RESET    = 1'b1;
        mem_read = 1'b0;
        #1;
        check_output("rstmid_strobe_off", 32'(dm_bus.dm_read), 32'd0);
        check_output("rstmid_rdo", read_data_out, 32'h0);
        check_output("rstmid_addr", 32'(dm_bus.dm_address), 32'h0);
        check_output("rstmid_busy", 32'(busywait), 32'd0);
        @(posedge CLK); #1;
        RESET   = 1'b0;
        last_rd = 32'h0;
        @(posedge CLK); #1;

        $display("[TB] back-to-back loads");
        start_cycle = cycle_count;
        exp_q.push_back(32'h1122_3344);
        apply_stimulus(1'b1, 1'b0, 3'b010, 32'h0000_0008, 32'h0, 32'h1122_3344, 1);
        check_output("b2b1_busy_cycles", 32'(busy_cycles), 32'd2);
        check_done("b2b1", 1'b0);
        @(posedge CLK); #1;
        check_output("b2b1_total_cycles", 32'(cycle_count - start_cycle), 32'd3);
        start_cycle = cycle_count;
        exp_q.push_back(32'hFFFF_9ABC);
        apply_stimulus(1'b1, 1'b0, 3'b001, 32'h0000_000E, 32'h0, 32'h9ABC_5555, 1);
        check_done("b2b2", 1'b0);
        @(posedge CLK); #1;
        check_output("b2b2_total_cycles", 32'(cycle_count - start_cycle), 32'd3);
        go_idle();

        $display("[TB] memory timeout");
        exp_q.push_back(32'h0);
        apply_stimulus(1'b1, 1'b0, 3'b010, 32'h0000_0020, 32'h0, 32'h0, 0);
        check_output("to_busy_cycles", 32'(busy_cycles), 32'd65);
        check_output("to_strobe_cycles", 32'(strobe_cycles), 32'd64);
        check_done("timeout", 1'b1);
        go_idle();
        check_output("to_fault_pulse", 32'(access_fault), 32'd0);
        check_output("to_idle_busy", 32'(busywait), 32'd0);
        check_output("sb_empty", 32'(exp_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
